// File: rtl/trans_seq_pkg.sv
// trans_seq_pkg: shared FSM states, beat geometry and strobe/beat helpers for trans_buf_sequencer.
//  seq_state_e  IDLE/TX/RX/DONE
//  BEAT_BYTES   bytes per 64-bit beat
//  beats_calc   number of beats touched by a burst (offs, len-1)
//  strb_first   byte strobe of the first beat
//  strb_last    byte strobe of the last beat from its end byte index
package trans_seq_pkg;
   typedef enum logic [1:0] {IDLE, TX, RX, DONE} seq_state_e;
   localparam int BEAT_BYTES = 8;
   function automatic logic [32:0] beats_calc(input logic [2:0] offs, input logic [31:0] len);
      return (({30'd0, offs} + {1'b0, len}) >> $clog2(BEAT_BYTES)) + 33'd1;
   endfunction
   function automatic logic [7:0] strb_first(input logic [2:0] offs);
      return 8'hFF << offs;
   endfunction
   function automatic logic [7:0] strb_last(input logic [2:0] e);
      return 8'hFF >> (3'd7 - e);
   endfunction
endpackage

// File: rtl/trans_buf_sequencer_if.sv
// trans_buf_sequencer_if: command, TX/RX buffer and ext-bus handshake bundle of the sequencer.
//  slave modport  : sequencer view (cmd_*_i, tx_pop_gnt_i, ext_tx_ready_i, ext_rx_valid_i, rx_push_gnt_i in)
//  master modport : environment view (command source, buffers and ext bus)
//  TRANS_SEQ_STALL_CNT_EN adds stall_cnt_o.
interface trans_buf_sequencer_if #(parameter int LEN_WIDTH = 16);
   logic                 cmd_req_i;
   logic                 cmd_gnt_o;
   logic                 cmd_rx_i;
   logic [LEN_WIDTH-1:0] cmd_len_i;
   logic [2:0]           cmd_offs_i;
   logic                 tx_pop_req_o;
   logic                 tx_pop_gnt_i;
   logic                 ext_tx_valid_o;
   logic                 ext_tx_ready_i;
   logic [7:0]           ext_tx_strb_o;
   logic                 ext_tx_last_o;
   logic                 ext_rx_valid_i;
   logic                 ext_rx_ready_o;
   logic                 rx_push_req_o;
   logic                 rx_push_gnt_i;
   logic [7:0]           rx_push_strb_o;
   logic                 busy_o;
   logic                 done_o;
`ifdef TRANS_SEQ_STALL_CNT_EN
   logic [31:0]          stall_cnt_o;
`endif
   modport slave (
      input  cmd_req_i, cmd_rx_i, cmd_len_i, cmd_offs_i, tx_pop_gnt_i, ext_tx_ready_i,
             ext_rx_valid_i, rx_push_gnt_i,
      output cmd_gnt_o, tx_pop_req_o, ext_tx_valid_o, ext_tx_strb_o, ext_tx_last_o,
             ext_rx_ready_o, rx_push_req_o, rx_push_strb_o, busy_o, done_o
`ifdef TRANS_SEQ_STALL_CNT_EN
      , output stall_cnt_o
`endif
   );
   modport master (
      output cmd_req_i, cmd_rx_i, cmd_len_i, cmd_offs_i, tx_pop_gnt_i, ext_tx_ready_i,
             ext_rx_valid_i, rx_push_gnt_i,
      input  cmd_gnt_o, tx_pop_req_o, ext_tx_valid_o, ext_tx_strb_o, ext_tx_last_o,
             ext_rx_ready_o, rx_push_req_o, rx_push_strb_o, busy_o, done_o
`ifdef TRANS_SEQ_STALL_CNT_EN
      , input stall_cnt_o
`endif
   );
endinterface

// File: rtl/trans_strb_gen.sv
// trans_strb_gen: byte strobe of the current beat from first/last flags, shared by TX and RX.
//  i_first, i_last          current beat is first / last
//  i_first_strb, i_last_strb latched edge strobes
//  o_strb                   resulting byte strobe
module trans_strb_gen (
   input  logic       i_first,
   input  logic       i_last,
   input  logic [7:0] i_first_strb,
   input  logic [7:0] i_last_strb,
   output logic [7:0] o_strb
);
   assign o_strb = (i_first ? i_first_strb : 8'hFF) & (i_last ? i_last_strb : 8'hFF);
endmodule

// File: rtl/trans_buf_sequencer.sv
// trans_buf_sequencer: splits one ext-side burst into 64-bit beats and gates TX pop / RX push handshakes.
//  clk_i, rst_i  clock, synchronous active-high reset
//  bus           trans_buf_sequencer_if.slave (command, TX buffer pop, ext TX/RX, RX buffer push, status)
//  TRANS_SEQ_STALL_CNT_EN adds bus.stall_cnt_o, the count of active cycles without a completed beat.
module trans_buf_sequencer
   import trans_seq_pkg::*;
#(
   parameter int LEN_WIDTH  = 16,
   parameter int BEAT_WIDTH = 13
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   trans_buf_sequencer_if.slave  bus
);
   // the counter must hold 2^(LEN_WIDTH-3)+1 beats, so never narrower than LEN_WIDTH-2
   localparam int CW = (BEAT_WIDTH > LEN_WIDTH - 2) ? BEAT_WIDTH : LEN_WIDTH - 2;
   seq_state_e    r_state, w_next;
   logic [CW-1:0] r_beats;
   logic          r_first;
   logic [7:0]    r_fstrb, r_lstrb;
   logic [7:0]    w_strb;
   logic [2:0]    w_end;
   logic          w_tx, w_rx, w_last, w_beat, w_accept;
   assign w_tx     = r_state == TX;
   assign w_rx     = r_state == RX;
   assign w_last   = r_beats == CW'(1);
   assign w_end    = bus.cmd_offs_i + bus.cmd_len_i[2:0];
   assign w_accept = bus.cmd_req_i & bus.cmd_gnt_o;
   trans_strb_gen u_strb (
      .i_first      (r_first),
      .i_last       (w_last),
      .i_first_strb (r_fstrb),
      .i_last_strb  (r_lstrb),
      .o_strb       (w_strb)
   );
   // pure gating: a beat completes in the same cycle both sides handshake
   assign bus.ext_tx_valid_o = w_tx & bus.tx_pop_gnt_i;
   assign bus.tx_pop_req_o   = bus.ext_tx_valid_o & bus.ext_tx_ready_i;
   assign bus.ext_tx_strb_o  = w_tx ? w_strb : 8'h00;
   assign bus.ext_tx_last_o  = w_tx & w_last;
   assign bus.ext_rx_ready_o = w_rx & bus.rx_push_gnt_i;
   assign bus.rx_push_req_o  = w_rx & bus.ext_rx_valid_i & bus.rx_push_gnt_i;
   assign bus.rx_push_strb_o = w_rx ? w_strb : 8'h00;
   assign bus.cmd_gnt_o      = r_state == IDLE;
   assign bus.busy_o         = r_state != IDLE;
   assign bus.done_o         = r_state == DONE;
   assign w_beat             = bus.tx_pop_req_o | bus.rx_push_req_o;
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    w_next = w_accept ? (bus.cmd_rx_i ? RX : TX) : IDLE;
         TX, RX:  w_next = (w_beat && w_last) ? DONE : r_state;
         default: w_next = IDLE;
      endcase
   end
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= IDLE;
         r_beats <= '0;
         r_first <= 1'b0;
         r_fstrb <= 8'h00;
         r_lstrb <= 8'h00;
      end else begin
         r_state <= w_next;
         if (w_accept) begin
            r_beats <= CW'(beats_calc(bus.cmd_offs_i, 32'(bus.cmd_len_i)));
            r_first <= 1'b1;
            r_fstrb <= strb_first(bus.cmd_offs_i);
            r_lstrb <= strb_last(w_end);
         end else if (w_beat) begin
            r_beats <= r_beats - CW'(1);
            r_first <= 1'b0;
         end
      end
   end
`ifdef TRANS_SEQ_STALL_CNT_EN
   logic [31:0] r_stall;
   assign bus.stall_cnt_o = r_stall;
   always_ff @(posedge clk_i) begin
      if (rst_i || w_accept)
         r_stall <= '0;
      else if ((w_tx || w_rx) && !w_beat && r_stall != '1)
         r_stall <= r_stall + 32'd1;
   end
`endif
endmodule
